// File: rtl/lbp_pkg.sv
// Shared types for the streaming LBP engine: FSM states,
// read counts and the neighbour-to-code-bit map.
package lbp_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILL   = 3'd1,
      SHIFT  = 3'd2,
      WRITE  = 3'd3,
      BORDER = 3'd4,
      DONE   = 3'd5
   } lbp_state_t;

   localparam int FILL_READS  = 9;
   localparam int SHIFT_READS = 3;

   // row-major window slot feeding each code bit; slot 4 is the centre
   localparam int NB_IDX [8] = '{0, 1, 2, 3, 5, 6, 7, 8};
   localparam int CENTER_IDX = 4;

endpackage

// File: rtl/lbp_window3x3.sv
// 3x3 pixel window with indexed load, left shift and the
// thresholded neighbour compare that forms the LBP code.
module lbp_window3x3
   import lbp_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_en,
   input  logic [3:0]    ld_idx,
   input  logic [DW-1:0] ld_data,
   input  logic          shift,
   input  logic [DW-1:0] thr,
   output logic [7:0]    code
);

   logic [DW-1:0] win [9];
   logic [DW:0]   level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) win[i] <= '0;
      end else if (shift) begin
         win[0] <= win[1];
         win[1] <= win[2];
         win[3] <= win[4];
         win[4] <= win[5];
         win[6] <= win[7];
         win[7] <= win[8];
      end else if (ld_en) begin
         win[ld_idx] <= ld_data;
      end
   end

   // one extra bit so centre+thr never wraps back into range
   assign level = {1'b0, win[CENTER_IDX]} + {1'b0, thr};

   always_comb begin
      code = '0;
      for (int b = 0; b < 8; b++)
         code[b] = ({1'b0, win[NB_IDX[b]]} >= level);
   end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: reads a gray frame, writes one code
// per interior pixel, optionally zero-fills the border.
module lbp_stream_engine
   import lbp_pkg::*;
#(
   parameter int IMG_W       = 128,
   parameter int IMG_H       = 128,
   parameter int DW          = 8,
   parameter int BORDER_ZERO = 0,
   parameter int AW          = $clog2(IMG_W*IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          gray_ready,
   input  logic [DW-1:0] lbp_thr,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   output logic          lbp_valid,
   input  logic          lbp_ready,
   output logic [AW-1:0] lbp_addr,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   localparam logic [AW-1:0] ONE    = AW'(1);
   localparam logic [AW-1:0] THREE  = AW'(3);
   localparam logic [AW-1:0] W_A    = AW'(IMG_W);
   localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 2);
   localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 2);
   localparam logic [AW-1:0] EDGE_C = AW'(IMG_W - 1);
   localparam logic [AW-1:0] EDGE_R = AW'(IMG_H - 1);
   localparam logic [AW-1:0] LAST_A = AW'(IMG_W*IMG_H - 1);

   lbp_state_t    state, state_nx;
   logic [3:0]    cnt, ld_idx;
   logic [AW-1:0] pix, row, col, addr_q;
   logic [AW-1:0] rd_addr, fill_off, shift_off;
   logic [DW-1:0] thr_q;
   logic [7:0]    code;
   logic          ld_en, shift, row_end, frame_end;

   assign row_end   = (col == LAST_C);
   assign frame_end = (row == LAST_R);
   assign lbp_addr  = pix;
   assign gray_addr = gray_req ? rd_addr : addr_q;

   always_comb begin
      fill_off = '0;
      unique case (1'b1)
         (cnt < 4'd3):                 fill_off = AW'(cnt);
         (cnt >= 4'd3 && cnt < 4'd6):  fill_off = W_A + AW'(cnt - 4'd3);
         (cnt >= 4'd6):                fill_off = W_A + W_A + AW'(cnt - 4'd6);
      endcase
   end

   always_comb begin
      shift_off = '0;
      unique case (1'b1)
         (cnt == 4'd1): shift_off = W_A;
         (cnt == 4'd2): shift_off = W_A + W_A;
         (cnt != 4'd1 && cnt != 4'd2): shift_off = '0;
      endcase
   end

   always_comb begin
      state_nx  = state;
      gray_req  = 1'b0;
      rd_addr   = addr_q;
      ld_en     = 1'b0;
      ld_idx    = '0;
      shift     = 1'b0;
      lbp_valid = 1'b0;
      lbp_data  = '0;
      finish    = 1'b0;
      case (state)
         IDLE: if (gray_ready) state_nx = FILL;
         FILL: begin
            gray_req = (cnt < 4'(FILL_READS));
            rd_addr  = pix - W_A - ONE + fill_off;
            ld_en    = (cnt != 4'd0);
            ld_idx   = cnt - 4'd1;
            if (cnt == 4'(FILL_READS)) state_nx = WRITE;
         end
         SHIFT: begin
            gray_req = (cnt < 4'(SHIFT_READS));
            rd_addr  = pix - W_A + ONE + shift_off;
            shift    = (cnt == 4'd0);
            ld_en    = (cnt != 4'd0);
            ld_idx   = (cnt == 4'd1) ? 4'd2 :
                       (cnt == 4'd2) ? 4'd5 : 4'd8;
            if (cnt == 4'(SHIFT_READS)) state_nx = WRITE;
         end
         WRITE: begin
            lbp_valid = 1'b1;
            lbp_data  = code;
            if (lbp_ready) begin
               if (!row_end)              state_nx = SHIFT;
               else if (!frame_end)       state_nx = FILL;
               else if (BORDER_ZERO != 0) state_nx = BORDER;
               else                       state_nx = DONE;
            end
         end
         BORDER: begin
            lbp_valid = 1'b1;
            if (lbp_ready && pix == LAST_A) state_nx = DONE;
         end
         DONE: begin
            finish   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         pix    <= '0;
         row    <= '0;
         col    <= '0;
         addr_q <= '0;
         thr_q  <= '0;
      end else begin
         if (gray_req) addr_q <= rd_addr;
         cnt <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
         case (state)
            IDLE: if (gray_ready) begin
               thr_q <= lbp_thr;
               row   <= ONE;
               col   <= ONE;
               pix   <= W_A + ONE;
            end
            WRITE: if (lbp_ready) begin
               if (!row_end) begin
                  col <= col + ONE;
                  pix <= pix + ONE;
               end else if (!frame_end) begin
                  row <= row + ONE;
                  col <= ONE;
                  pix <= pix + THREE;
               end else begin
                  row <= '0;
                  col <= '0;
                  pix <= '0;
               end
            end
            // interior rows jump straight from column 0 to the last column
            BORDER: if (lbp_ready) begin
               if (col == EDGE_C) begin
                  row <= row + ONE;
                  col <= '0;
                  pix <= pix + ONE;
               end else if (col == '0 && row != '0 && row != EDGE_R) begin
                  col <= EDGE_C;
                  pix <= pix + EDGE_C;
               end else begin
                  col <= col + ONE;
                  pix <= pix + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   lbp_window3x3 #(.DW(DW)) u_win (
      .clk     (clk),
      .reset   (reset),
      .ld_en   (ld_en),
      .ld_idx  (ld_idx),
      .ld_data (gray_data),
      .shift   (shift),
      .thr     (thr_q),
      .code    (code)
   );

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench for lbp_stream_engine: a 10x8 instance for the
// interior scan and a 4x3 border-fill instance.
module tb_lbp_stream_engine;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: 10x8, no border fill
   logic       a_gray_ready = 1'b0;
   logic [7:0] a_thr = '0;
   logic       a_req;
   logic [6:0] a_gaddr;
   logic [7:0] a_gdata = '0;
   logic       a_valid;
   logic       a_ready = 1'b1;
   logic [6:0] a_addr;
   logic [7:0] a_data;
   logic       a_finish;
   logic [7:0] mem_a [80];
   bit         rnd_ready = 1'b0;

   // instance B: 4x3 with border fill
   logic       b_gray_ready = 1'b0;
   logic [7:0] b_thr = '0;
   logic       b_req;
   logic [3:0] b_gaddr;
   logic [7:0] b_gdata = '0;
   logic       b_valid;
   logic       b_ready = 1'b1;
   logic [3:0] b_addr;
   logic [7:0] b_data;
   logic       b_finish;
   logic [7:0] mem_b [12];

   lbp_stream_engine #(.IMG_W(10), .IMG_H(8), .DW(8), .BORDER_ZERO(0)) dut_a (
      .clk(clk), .reset(reset), .gray_ready(a_gray_ready), .lbp_thr(a_thr),
      .gray_req(a_req), .gray_addr(a_gaddr), .gray_data(a_gdata),
      .lbp_valid(a_valid), .lbp_ready(a_ready), .lbp_addr(a_addr),
      .lbp_data(a_data), .finish(a_finish));

   lbp_stream_engine #(.IMG_W(4), .IMG_H(3), .DW(8), .BORDER_ZERO(1)) dut_b (
      .clk(clk), .reset(reset), .gray_ready(b_gray_ready), .lbp_thr(b_thr),
      .gray_req(b_req), .gray_addr(b_gaddr), .gray_data(b_gdata),
      .lbp_valid(b_valid), .lbp_ready(b_ready), .lbp_addr(b_addr),
      .lbp_data(b_data), .finish(b_finish));

   always @(posedge clk) if (a_req) a_gdata <= mem_a[a_gaddr];
   always @(posedge clk) if (b_req) b_gdata <= mem_b[b_gaddr];

   always @(posedge clk) begin
      #2;
      a_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic [6:0] qa_addr [$];
   logic [7:0] qa_data [$];
   logic [3:0] qb_addr [$];
   logic [7:0] qb_data [$];
   int a_fin = 0, a_reads = 0, a_stall_bad = 0, a_req_bad = 0;
   int b_fin = 0, b_reads = 0;
   logic       a_prev_stall = 1'b0;
   logic [6:0] a_prev_addr = '0;
   logic [7:0] a_prev_data = '0;

   always @(negedge clk) begin
      if (reset) begin
         a_prev_stall = 1'b0;
      end else begin
         if (a_valid && a_ready) begin
            qa_addr.push_back(a_addr);
            qa_data.push_back(a_data);
         end
         if (a_finish) a_fin++;
         if (a_req) a_reads++;
         if (a_valid && a_req) a_req_bad++;
         if (a_prev_stall && (!a_valid || a_addr !== a_prev_addr ||
             a_data !== a_prev_data)) a_stall_bad++;
         a_prev_stall = a_valid && !a_ready;
         a_prev_addr  = a_addr;
         a_prev_data  = a_data;
         if (b_valid && b_ready) begin
            qb_addr.push_back(b_addr);
            qb_data.push_back(b_data);
         end
         if (b_finish) b_fin++;
         if (b_req) b_reads++;
      end
   end

   function automatic logic [7:0] ref_code(int a, int thr);
      int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
      int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
      int ctr;
      logic [7:0] code = '0;
      ctr = int'(mem_a[a]);
      for (int b = 0; b < 8; b++)
         if (int'(mem_a[a + dr[b]*10 + dc[b]]) >= ctr + thr) code[b] = 1'b1;
      return code;
   endfunction

   function automatic int order_err_a(int q0);
      int e = 0;
      for (int k = 0; k < qa_addr.size() - q0; k++)
         if (int'(qa_addr[q0+k]) != (1 + k/8)*10 + 1 + k%8) e++;
      return e;
   endfunction

   function automatic int data_err_a(int q0, bit model, int thr, logic [7:0] want);
      int e = 0;
      logic [7:0] exp;
      for (int k = q0; k < qa_data.size(); k++) begin
         exp = model ? ref_code(int'(qa_addr[k]), thr) : want;
         if (qa_data[k] !== exp) e++;
      end
      return e;
   endfunction

   task automatic run_a(input logic [7:0] thr, output bit to);
      @(negedge clk);
      a_thr = thr;
      a_gray_ready = 1'b1;
      @(negedge clk);
      a_gray_ready = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (a_finish) begin
            to = 1'b0;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({a_req, a_gaddr, a_valid, a_addr, a_data, a_finish} !== 25'd0) begin
         errors++;
         $display("FAIL reset_a: got %h want 0",
                  {a_req, a_gaddr, a_valid, a_addr, a_data, a_finish});
      end
      checks++;
      if ({b_req, b_gaddr, b_valid, b_addr, b_data, b_finish} !== 19'd0) begin
         errors++;
         $display("FAIL reset_b: got %h want 0",
                  {b_req, b_gaddr, b_valid, b_addr, b_data, b_finish});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_constant();
      int q0, f0, r0, n;
      bit to;
      for (int i = 0; i < 80; i++) mem_a[i] = 8'h40;
      q0 = qa_addr.size(); f0 = a_fin; r0 = a_reads;
      run_a(8'h00, to);
      n = qa_addr.size() - q0;
      checks++;
      if (to) begin errors++; $display("FAIL const_timeout: no finish within bound"); end
      checks++;
      if (n != 48) begin errors++; $display("FAIL const_count: got %0d want 48", n); end
      checks++;
      if (n > 0 && qa_addr[q0] !== 7'd11) begin
         errors++; $display("FAIL const_first: got %0d want 11", qa_addr[q0]);
      end
      checks++;
      if (n > 0 && qa_addr[qa_addr.size()-1] !== 7'd68) begin
         errors++; $display("FAIL const_last: got %0d want 68", qa_addr[qa_addr.size()-1]);
      end
      checks++;
      if (order_err_a(q0) != 0) begin
         errors++; $display("FAIL const_order: got %0d bad want 0", order_err_a(q0));
      end
      checks++;
      if (data_err_a(q0, 1'b0, 0, 8'hFF) != 0) begin
         errors++; $display("FAIL const_data: got %0d bad want 0", data_err_a(q0, 1'b0, 0, 8'hFF));
      end
      checks++;
      if (a_fin - f0 != 1) begin
         errors++; $display("FAIL const_finish: got %0d want 1", a_fin - f0);
      end
      checks++;
      if (a_reads - r0 != 180) begin
         errors++; $display("FAIL const_reads: got %0d want 180", a_reads - r0);
      end
   endtask

   task automatic test_ramp();
      int q0, n;
      bit to;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 10; c++) mem_a[r*10+c] = 8'(c);
      q0 = qa_addr.size();
      run_a(8'h00, to);
      n = qa_addr.size() - q0;
      checks++;
      if (to || n != 48) begin
         errors++; $display("FAIL ramp0_count: got %0d want 48 (timeout %0d)", n, to);
      end
      checks++;
      if (data_err_a(q0, 1'b0, 0, 8'hD6) != 0) begin
         errors++; $display("FAIL ramp0_data: got %0d bad want 0", data_err_a(q0, 1'b0, 0, 8'hD6));
      end
      q0 = qa_addr.size();
      run_a(8'h01, to);
      n = qa_addr.size() - q0;
      checks++;
      if (to || n != 48) begin
         errors++; $display("FAIL ramp1_count: got %0d want 48 (timeout %0d)", n, to);
      end
      checks++;
      if (data_err_a(q0, 1'b0, 0, 8'h94) != 0) begin
         errors++; $display("FAIL ramp1_data: got %0d bad want 0", data_err_a(q0, 1'b0, 0, 8'h94));
      end
   endtask

   task automatic test_threshold_edge();
      int q0;
      bit to;
      logic [7:0] pix [3] = '{8'h40, 8'hFF, 8'h80};
      logic [7:0] thr [3] = '{8'hFF, 8'h01, 8'h7F};
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 80; i++) mem_a[i] = pix[t];
         q0 = qa_addr.size();
         run_a(thr[t], to);
         checks++;
         if (to || qa_addr.size() - q0 != 48 || data_err_a(q0, 1'b0, 0, 8'h00) != 0) begin
            errors++;
            $display("FAIL thr_edge_%0d: got %0d writes %0d bad want 48 writes 0 bad",
                     t, qa_addr.size() - q0, data_err_a(q0, 1'b0, 0, 8'h00));
         end
      end
   endtask

   task automatic test_random_backpressure();
      int q0, s0, g0, f0, n;
      bit to;
      for (int i = 0; i < 80; i++) mem_a[i] = 8'($urandom_range(0, 255));
      q0 = qa_addr.size(); s0 = a_stall_bad; g0 = a_req_bad; f0 = a_fin;
      rnd_ready = 1'b1;
      run_a(8'h05, to);
      rnd_ready = 1'b0;
      n = qa_addr.size() - q0;
      checks++;
      if (to || n != 48) begin
         errors++; $display("FAIL rand_count: got %0d want 48 (timeout %0d)", n, to);
      end
      checks++;
      if (order_err_a(q0) != 0) begin
         errors++; $display("FAIL rand_order: got %0d bad want 0", order_err_a(q0));
      end
      checks++;
      if (data_err_a(q0, 1'b1, 5, 8'h00) != 0) begin
         errors++; $display("FAIL rand_data: got %0d bad want 0", data_err_a(q0, 1'b1, 5, 8'h00));
      end
      checks++;
      if (a_stall_bad - s0 != 0) begin
         errors++; $display("FAIL rand_stall_stable: got %0d changes want 0", a_stall_bad - s0);
      end
      checks++;
      if (a_req_bad - g0 != 0) begin
         errors++; $display("FAIL rand_req_in_write: got %0d want 0", a_req_bad - g0);
      end
      checks++;
      if (a_fin - f0 != 1) begin
         errors++; $display("FAIL rand_finish: got %0d want 1", a_fin - f0);
      end
   endtask

   task automatic test_border();
      logic [3:0] exp_a [12] = '{5, 6, 0, 1, 2, 3, 4, 7, 8, 9, 10, 11};
      logic [7:0] exp_d [12] = '{8'hF0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int q0, f0, r0, n, bad;
      bit to;
      for (int i = 0; i < 12; i++) mem_b[i] = 8'(i);
      q0 = qb_addr.size(); f0 = b_fin; r0 = b_reads;
      @(negedge clk);
      b_thr = 8'h00;
      b_gray_ready = 1'b1;
      @(negedge clk);
      b_gray_ready = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (b_finish) begin
            to = 1'b0;
            break;
         end
      end
      @(negedge clk);
      n = qb_addr.size() - q0;
      checks++;
      if (to || n != 12) begin
         errors++; $display("FAIL border_count: got %0d want 12 (timeout %0d)", n, to);
      end
      bad = 0;
      for (int k = 0; k < 12 && k < n; k++)
         if (qb_addr[q0+k] !== exp_a[k] || qb_data[q0+k] !== exp_d[k]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL border_seq: got %0d bad entries want 0", bad);
      end
      checks++;
      if (b_fin - f0 != 1) begin
         errors++; $display("FAIL border_finish: got %0d want 1", b_fin - f0);
      end
      checks++;
      if (b_reads - r0 != 12) begin
         errors++; $display("FAIL border_reads: got %0d want 12", b_reads - r0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int q0;
      bit hit, to;
      for (int i = 0; i < 80; i++) mem_a[i] = 8'h40;
      @(negedge clk);
      a_thr = 8'h00;
      a_gray_ready = 1'b1;
      @(negedge clk);
      a_gray_ready = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (a_valid && a_ready && a_addr == 7'd52) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL midrst_reach: addr 52 never written"); end
      @(negedge clk);
      checks++;
      if (a_req !== 1'b1) begin
         errors++; $display("FAIL midrst_shift_read: got %0d want 1", a_req);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({a_req, a_gaddr, a_valid, a_addr, a_data, a_finish} !== 25'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got %h want 0",
                  {a_req, a_gaddr, a_valid, a_addr, a_data, a_finish});
      end
      @(negedge clk);
      reset = 1'b0;
      q0 = qa_addr.size();
      run_a(8'h00, to);
      checks++;
      if (to || qa_addr.size() - q0 != 48) begin
         errors++; $display("FAIL midrst_count: got %0d want 48 (timeout %0d)", qa_addr.size() - q0, to);
      end
      checks++;
      if (qa_addr.size() > q0 && qa_addr[q0] !== 7'd11) begin
         errors++; $display("FAIL midrst_first: got %0d want 11", qa_addr[q0]);
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_ramp();
      test_threshold_edge();
      test_random_backpressure();
      test_border();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
